// File: rtl/jpeg_zzrle.sv
// Zigzag scan and run-length coder for one 8x8 block of quantized coefficients.
// Define JPEG_ZZRLE_DC_PRED_EN to code DC differentially against the previous block.
module jpeg_zzrle (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        dc_clr_i,
    output logic [4:0]  rd_addr_o,
    input  logic [31:0] rd_data_i,
    output logic        sym_valid_o,
    input  logic        sym_ready_i,
    output logic [3:0]  sym_run_o,
    output logic [3:0]  sym_size_o,
    output logic [11:0] sym_amp_o,
    output logic        sym_dc_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {IDLE, FETCH, EVAL, EMIT, DONE} state_t;

    localparam logic [5:0] ZZ [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Returns {size, amp} for a signed value.
    function automatic logic [15:0] enc(input logic signed [12:0] x);
        logic [12:0] mag;
        logic [12:0] m1;
        logic [11:0] mask;
        logic [3:0]  sz;
        mag = x[12] ? 13'(-x) : 13'(x);
        sz  = 4'd0;
        for (int b = 0; b < 12; b++)
            if (mag[b]) sz = 4'(b + 1);
        mask = 12'((13'd1 << sz) - 13'd1);
        m1   = x[12] ? 13'(x - 13'sd1) : 13'(x);
        return {sz, m1[11:0] & mask};
    endfunction

    state_t             state, state_n;
    logic [5:0]         idx;
    logic [5:0]         run;
    logic signed [12:0] v_q;
    logic               zrl_q;
    logic               end_q;

    logic [5:0]         nat;
    logic signed [15:0] raw;
    logic signed [11:0] coef;
    logic signed [12:0] v;
    logic [15:0]        e_new;
    logic [15:0]        e_q;
    logic               xfer;

    assign nat  = ZZ[idx];
    assign raw  = nat[0] ? rd_data_i[15:0] : rd_data_i[31:16];
    assign xfer = (state == EMIT) && sym_ready_i;

    always_comb begin
        if (raw > 16'sd2047)
            coef = 12'sd2047;
        else if (raw < -16'sd2047)
            coef = -12'sd2047;
        else
            coef = raw[11:0];
    end

`ifdef JPEG_ZZRLE_DC_PRED_EN
    logic signed [11:0] pred;

    always_comb begin
        if (idx == 6'd0)
            v = {coef[11], coef} - {pred[11], pred};
        else
            v = {coef[11], coef};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            pred <= '0;
        else if (state == IDLE && dc_clr_i)
            pred <= '0;
        else if (state == EVAL && idx == 6'd0)
            pred <= coef;
    end
`else
    logic unused_dc_clr;

    assign unused_dc_clr = dc_clr_i;
    assign v = {coef[11], coef};
`endif

    assign e_new = enc(v);
    assign e_q   = enc(v_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start_i) state_n = FETCH;
            FETCH: state_n = EVAL;
            EVAL: begin
                if (idx != 6'd0 && coef == 12'sd0 && idx != 6'd63)
                    state_n = FETCH;
                else
                    state_n = EMIT;
            end
            EMIT: begin
                if (sym_ready_i) begin
                    if (zrl_q)
                        state_n = EMIT;
                    else if (end_q)
                        state_n = DONE;
                    else
                        state_n = FETCH;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sym_valid_o = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        rd_addr_o   = 5'd0;
        case (state)
            IDLE:    busy_o = 1'b0;
            FETCH:   rd_addr_o = nat[5:1];
            EMIT:    sym_valid_o = 1'b1;
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    // Payload only moves on entry to EMIT or on a transfer, so it holds under backpressure.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx        <= '0;
            run        <= '0;
            v_q        <= '0;
            zrl_q      <= 1'b0;
            end_q      <= 1'b0;
            sym_run_o  <= '0;
            sym_size_o <= '0;
            sym_amp_o  <= '0;
            sym_dc_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        idx   <= '0;
                        run   <= '0;
                        zrl_q <= 1'b0;
                        end_q <= 1'b0;
                    end
                end
                EVAL: begin
                    if (idx == 6'd0) begin
                        sym_run_o  <= 4'd0;
                        sym_size_o <= e_new[15:12];
                        sym_amp_o  <= e_new[11:0];
                        sym_dc_o   <= 1'b1;
                    end else if (coef == 12'sd0) begin
                        run <= run + 6'd1;
                        if (idx == 6'd63) begin
                            sym_run_o  <= 4'd0;
                            sym_size_o <= 4'd0;
                            sym_amp_o  <= 12'd0;
                            sym_dc_o   <= 1'b0;
                            end_q      <= 1'b1;
                        end else begin
                            idx <= idx + 6'd1;
                        end
                    end else begin
                        v_q      <= v;
                        end_q    <= (idx == 6'd63);
                        sym_dc_o <= 1'b0;
                        if (run >= 6'd16) begin
                            sym_run_o  <= 4'd15;
                            sym_size_o <= 4'd0;
                            sym_amp_o  <= 12'd0;
                            run        <= run - 6'd16;
                            zrl_q      <= 1'b1;
                        end else begin
                            sym_run_o  <= run[3:0];
                            sym_size_o <= e_new[15:12];
                            sym_amp_o  <= e_new[11:0];
                            run        <= '0;
                        end
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        if (zrl_q) begin
                            sym_dc_o <= 1'b0;
                            if (run >= 6'd16) begin
                                sym_run_o  <= 4'd15;
                                sym_size_o <= 4'd0;
                                sym_amp_o  <= 12'd0;
                                run        <= run - 6'd16;
                            end else begin
                                sym_run_o  <= run[3:0];
                                sym_size_o <= e_q[15:12];
                                sym_amp_o  <= e_q[11:0];
                                run        <= '0;
                                zrl_q      <= 1'b0;
                            end
                        end else if (!end_q) begin
                            idx <= idx + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
